draw_scheduler: RTL and testbench

DRAW_SCHEDULER -- requirements
Module: draw_scheduler

---
 rtl/draw_pkg.sv | 21 ++
 rtl/draw_watchdog.sv | 30 +++
 rtl/draw_scheduler.sv | 227 ++++++++++++++++++++++
 tb/tb_draw_scheduler.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared constants and state encoding for the layered draw scheduler.
package draw_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int C_W      = 3;
  localparam int NUM_ENG  = 3;
  localparam int WD_W     = 17;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_DONE,
    RELEASE,
    NEXT,
    FIN
  } state_t;

endpackage

// File: rtl/draw_watchdog.sv
// Per-engine hold-time watchdog: cleared on engine start, saturates at limit.
module draw_watchdog
  import draw_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 131071
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT_CYC);

  logic [WD_W-1:0] r_cnt;

  assign o_expired = (r_cnt >= LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + WD_W'(1);
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// Grants the VGA write port to draw engines one at a time, lowest index
// first, so higher engines paint over lower layers within each frame.
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int          NUM_ENG     = draw_pkg::NUM_ENG,
  parameter int unsigned TIMEOUT_CYC = 131071
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic [NUM_ENG-1:0]     en_mask,
  output logic [NUM_ENG-1:0]     begin_draw,
  input  logic [NUM_ENG-1:0]     eng_done,
  input  logic [X_W*NUM_ENG-1:0] eng_x,
  input  logic [Y_W*NUM_ENG-1:0] eng_y,
  input  logic [C_W*NUM_ENG-1:0] eng_color,
  input  logic [NUM_ENG-1:0]     eng_plot,
  output logic [X_W-1:0]         vga_x,
  output logic [Y_W-1:0]         vga_y,
  output logic [C_W-1:0]         vga_color,
  output logic                   vga_plot,
  output logic                   busy,
  output logic                   frame_done,
  output logic [7:0]             frame_count,
  output logic                   timeout_err,
  output logic                   overrun
);

  localparam int IDX_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_idx;
  logic [NUM_ENG-1:0] r_mask;
  logic               r_to_rel;
  logic               r_timeout_err;
  logic               r_overrun;
  logic [7:0]         r_count;
  logic [X_W-1:0]     r_vga_x;
  logic [Y_W-1:0]     r_vga_y;
  logic [C_W-1:0]     r_vga_c;
  logic               r_vga_plot;

  logic               w_first_ok;
  logic [IDX_W-1:0]   w_first;
  logic               w_nxt_ok;
  logic [IDX_W-1:0]   w_nxt;
  logic               w_done;
  logic               w_plot;
  logic [X_W-1:0]     w_x;
  logic [Y_W-1:0]     w_y;
  logic [C_W-1:0]     w_c;
  logic               w_wd_clr;
  logic               w_wd_en;
  logic               w_expired;
  logic               w_bd_on;
  logic               w_load;
  logic               w_adv;
  logic               w_to_hit;
  logic               w_frame_done;
  logic               w_cap;

  draw_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wd (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_wd_clr),
    .i_en     (w_wd_en),
    .o_expired(w_expired)
  );

  // Descending scan leaves the lowest qualifying index in the result.
  always_comb begin
    w_first_ok = 1'b0;
    w_first    = '0;
    w_nxt_ok   = 1'b0;
    w_nxt      = '0;
    for (int i = NUM_ENG - 1; i >= 0; i--) begin
      if (en_mask[i]) begin
        w_first_ok = 1'b1;
        w_first    = IDX_W'(i);
      end
      if (r_mask[i] && (i > int'(r_idx))) begin
        w_nxt_ok = 1'b1;
        w_nxt    = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_done = 1'b0;
    w_plot = 1'b0;
    w_x    = '0;
    w_y    = '0;
    w_c    = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_done = eng_done[i];
        w_plot = eng_plot[i];
        w_x    = eng_x[i*X_W +: X_W];
        w_y    = eng_y[i*Y_W +: Y_W];
        w_c    = eng_color[i*C_W +: C_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_wd_clr     = 1'b0;
    w_wd_en      = 1'b0;
    w_bd_on      = 1'b0;
    w_load       = 1'b0;
    w_adv        = 1'b0;
    w_to_hit     = 1'b0;
    w_frame_done = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (frame_tick) begin
          w_load = 1'b1;
          w_next = w_first_ok ? START : FIN;
        end
      end
      START: begin
        w_bd_on  = 1'b1;
        w_wd_clr = 1'b1;
        w_next   = WAIT_DONE;
      end
      WAIT_DONE: begin
        w_bd_on = 1'b1;
        w_wd_en = 1'b1;
        if (w_expired) begin
          w_to_hit = 1'b1;
          w_next   = RELEASE;
        end else if (w_done) begin
          w_next = RELEASE;
        end
      end
      RELEASE: begin
        // A hung engine may never drop done; the timeout path skips the wait.
        if (!w_done || r_to_rel) begin
          w_next = NEXT;
        end
      end
      NEXT: begin
        w_adv  = w_nxt_ok;
        w_next = w_nxt_ok ? START : FIN;
      end
      FIN: begin
        w_frame_done = 1'b1;
        w_next       = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_cap = (r_state == WAIT_DONE) && !w_expired;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx         <= '0;
      r_mask        <= '0;
      r_to_rel      <= 1'b0;
      r_timeout_err <= 1'b0;
      r_overrun     <= 1'b0;
      r_count       <= '0;
      r_vga_x       <= '0;
      r_vga_y       <= '0;
      r_vga_c       <= '0;
      r_vga_plot    <= 1'b0;
    end else begin
      if (w_load) begin
        r_mask <= en_mask;
        r_idx  <= w_first;
      end
      if (w_adv) begin
        r_idx <= w_nxt;
      end
      if (w_wd_clr) begin
        r_to_rel <= 1'b0;
      end
      if (w_to_hit) begin
        r_to_rel      <= 1'b1;
        r_timeout_err <= 1'b1;
      end
      if (frame_tick && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end
      if (w_frame_done) begin
        r_count <= r_count + 8'd1;
      end
      r_vga_plot <= w_cap & w_plot;
      r_vga_x    <= w_cap ? w_x : '0;
      r_vga_y    <= w_cap ? w_y : '0;
      r_vga_c    <= w_cap ? w_c : '0;
    end
  end

  always_comb begin
    begin_draw = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      if (w_bd_on && (r_idx == IDX_W'(i))) begin
        begin_draw[i] = 1'b1;
      end
    end
  end

  assign busy        = (r_state != IDLE);
  assign frame_done  = w_frame_done;
  assign frame_count = r_count;
  assign timeout_err = r_timeout_err;
  assign overrun     = r_overrun;
  assign vga_x       = r_vga_x;
  assign vga_y       = r_vga_y;
  assign vga_color   = r_vga_c;
  assign vga_plot    = r_vga_plot;

endmodule

// File: tb/tb_draw_scheduler.sv
// Self-checking bench: engine models, start-order scoreboard, frame vectors.
module tb_draw_scheduler;

  localparam int ENG_DLY = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic [2:0]  en_mask;
  logic [2:0]  begin_draw;
  logic [2:0]  eng_done = '0;
  logic [23:0] eng_x;
  logic [20:0] eng_y;
  logic [8:0]  eng_color;
  logic [2:0]  eng_plot = '0;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_color;
  logic        vga_plot;
  logic        busy;
  logic        frame_done;
  logic [7:0]  frame_count;
  logic        timeout_err;
  logic        overrun;

  logic [2:0]  hang = '0;
  int          e_cnt [3];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          n_starts = 0;
  int          n_fd = 0;
  int          exp_count = 0;
  int          q [$];
  logic [2:0]  prev_bd = '0;

  typedef struct {
    logic [2:0] mask;
    int         exp_starts;
    logic       exp_to;
  } vec_t;

  vec_t tab [5];

  assign eng_x     = {8'd100, 8'd5, 8'd1};
  assign eng_y     = {7'd50, 7'd7, 7'd2};
  assign eng_color = {3'd3, 3'd6, 3'd1};

  draw_scheduler #(
    .NUM_ENG    (3),
    .TIMEOUT_CYC(100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .en_mask    (en_mask),
    .begin_draw (begin_draw),
    .eng_done   (eng_done),
    .eng_x      (eng_x),
    .eng_y      (eng_y),
    .eng_color  (eng_color),
    .eng_plot   (eng_plot),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_color  (vga_color),
    .vga_plot   (vga_plot),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_count(frame_count),
    .timeout_err(timeout_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Engines plot while started, raise done after ENG_DLY, drop it on release.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!begin_draw[i]) begin
        e_cnt[i]    <= 0;
        eng_done[i] <= 1'b0;
        eng_plot[i] <= 1'b0;
      end else if (e_cnt[i] >= ENG_DLY - 1 && !hang[i]) begin
        eng_done[i] <= 1'b1;
        eng_plot[i] <= 1'b0;
      end else begin
        e_cnt[i]    <= e_cnt[i] + 1;
        eng_plot[i] <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    int         e;
    logic [2:0] want;
    if (begin_draw != 3'b000 && prev_bd == 3'b000) begin
      n_starts++;
      n_checks++;
      if (q.size() == 0) begin
        n_errors++;
        $display("FAIL start_order act=%b exp=none", begin_draw);
      end else begin
        e = q.pop_front();
        want = '0;
        want[e] = 1'b1;
        if (begin_draw !== want) begin
          n_errors++;
          $display("FAIL start_order act=%b exp=%b", begin_draw, want);
        end
      end
    end
    if (frame_done === 1'b1) n_fd++;
    prev_bd = begin_draw;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic push_mask(input logic [2:0] m);
    for (int i = 0; i < 3; i++) begin
      if (m[i]) q.push_back(i);
    end
  endtask

  task automatic tick(input logic [2:0] m);
    @(negedge clk);
    en_mask    = m;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    en_mask    = 3'($urandom);
  endtask

  task automatic wait_frame(input string nm);
    int n = 0;
    while (frame_done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {31'd0, frame_done}, 32'd1);
    exp_count = (exp_count + 1) % 256;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end

  initial begin
    int fd0;
    int s0;
    int t0;
    int n;

    tab[0] = '{3'b111, 3, 1'b0};
    tab[1] = '{3'b101, 2, 1'b0};
    tab[2] = '{3'b000, 0, 1'b0};
    tab[3] = '{3'b010, 1, 1'b0};
    tab[4] = '{3'b100, 1, 1'b0};

    reset      = 1'b1;
    frame_tick = 1'b0;
    en_mask    = '0;
    repeat (3) @(negedge clk);
    chk("rst_begin", 32'(begin_draw), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(frame_count), 0);
    chk("rst_plot", 32'(vga_plot), 0);
    chk("rst_fdone", 32'(frame_done), 0);
    chk("rst_err", 32'({timeout_err, overrun}), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      fd0 = n_fd;
      s0  = n_starts;
      push_mask(tab[v].mask);
      tick(tab[v].mask);
      wait_frame($sformatf("vec%0d_done", v));
      chk($sformatf("vec%0d_count", v), 32'(frame_count), 32'(exp_count));
      chk($sformatf("vec%0d_pulses", v), 32'(n_fd - fd0), 1);
      chk($sformatf("vec%0d_starts", v), 32'(n_starts - s0),
          32'(tab[v].exp_starts));
      chk($sformatf("vec%0d_pending", v), 32'(q.size()), 0);
      chk($sformatf("vec%0d_busy", v), 32'(busy), 0);
      chk($sformatf("vec%0d_to", v), 32'(timeout_err), 32'(tab[v].exp_to));
      chk($sformatf("vec%0d_ovr", v), 32'(overrun), 0);
    end

    // Registered VGA path for engine 1.
    push_mask(3'b010);
    tick(3'b010);
    n = 0;
    while (!eng_plot[1] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("vga_latency", 32'(vga_plot), 0);
    @(negedge clk);
    chk("vga_x", 32'(vga_x), 5);
    chk("vga_y", 32'(vga_y), 7);
    chk("vga_c", 32'(vga_color), 6);
    chk("vga_plot", 32'(vga_plot), 1);
    n = 0;
    while (begin_draw != 3'b000 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("vga_rel_plot", 32'(vga_plot), 0);
    @(negedge clk);
    chk("vga_rel_plot2", 32'(vga_plot), 0);
    chk("vga_rel_x", 32'(vga_x), 0);
    wait_frame("vga_done");

    // Engine 0 hangs; watchdog must release it and move on to engine 1.
    hang = 3'b001;
    s0   = n_starts;
    push_mask(3'b011);
    tick(3'b011);
    n = 0;
    while (!begin_draw[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    t0 = cyc;
    n  = 0;
    while (!timeout_err && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("to_latency", 32'(cyc - t0), 102);
    chk("to_plot", 32'(vga_plot), 0);
    chk("to_release", 32'(begin_draw), 0);
    wait_frame("to_done");
    hang = 3'b000;
    chk("to_starts", 32'(n_starts - s0), 2);
    chk("to_sticky", 32'(timeout_err), 1);
    chk("to_count", 32'(frame_count), 32'(exp_count));

    // Second tick mid-frame is dropped.
    chk("ovr_pre", 32'(overrun), 0);
    fd0 = n_fd;
    push_mask(3'b111);
    tick(3'b111);
    repeat (5) @(negedge clk);
    en_mask    = 3'b111;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("ovr_flag", 32'(overrun), 1);
    wait_frame("ovr_done");
    repeat (20) @(negedge clk);
    chk("ovr_count", 32'(frame_count), 32'(exp_count));
    chk("ovr_pulses", 32'(n_fd - fd0), 1);
    chk("ovr_busy", 32'(busy), 0);
    chk("ovr_pending", 32'(q.size()), 0);

    // Asynchronous reset in the middle of engine 0's turn.
    push_mask(3'b111);
    tick(3'b111);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("arst_begin", 32'(begin_draw), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_count", 32'(frame_count), 0);
    chk("arst_vga", 32'({vga_plot, vga_x, vga_y, vga_color}), 0);
    chk("arst_flags", 32'({frame_done, timeout_err, overrun}), 0);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    exp_count = 0;
    fd0 = n_fd;
    s0  = n_starts;
    push_mask(3'b111);
    tick(3'b111);
    wait_frame("arst_done");
    chk("arst_count2", 32'(frame_count), 32'(exp_count));
    chk("arst_starts", 32'(n_starts - s0), 3);
    chk("arst_pulses", 32'(n_fd - fd0), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
